// File: rtl/fetch_unit.sv
// Instruction-fetch stage with a single-entry IF/ID output slot.
// One imem request in flight at most; redirect flushes the slot and squashes any stale response.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        req_fire;
    logic        resp_take;

    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return target & ~32'h0000_0003;
    endfunction

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_take = (state == S_WAIT) && imem_resp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // A response that lands with a redirect retires the old request, so never park in KILL then.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_nxt = S_REQ;
                end else if (redirect_valid) begin
                    state_nxt = S_KILL;
                end
            end
            S_KILL: begin
                if (imem_resp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = (state == S_REQ) && !rst && !redirect_valid && (!id_valid || id_ready);
        imem_addr      = pc;
    end

    // Redirect beats any same-edge response or refill of the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc       <= align_pc(redirect_pc);
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (resp_take) begin
            pc       <= pc + 32'd4;
            id_valid <= 1'b1;
            id_instr <= imem_resp_data;
            id_pc    <= pc;
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model (outstanding flag, discard flag, one-entry slot).
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_ipc   = 32'h0;
    bit          m_full  = 1'b0;
    bit          m_out   = 1'b0;
    bit          m_disc  = 1'b0;
    bit          m_init  = 1'b0;
    bit          m_fire;

    function automatic bit exp_req();
        return !rst && !m_out && !redirect_valid && (!m_full || id_ready);
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_pc    = 32'h0;
            m_instr = NOP;
            m_ipc   = 32'h0;
            m_full  = 1'b0;
            m_out   = 1'b0;
            m_disc  = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            m_fire = exp_req() && imem_req_ready;
            if (redirect_valid) begin
                m_pc    = {redirect_pc[31:2], 2'b00};
                m_full  = 1'b0;
                m_instr = NOP;
                if (m_out && imem_resp_valid) begin
                    m_out  = 1'b0;
                    m_disc = 1'b0;
                end else if (m_out) begin
                    m_disc = 1'b1;
                end
            end else if (m_out && imem_resp_valid) begin
                m_out = 1'b0;
                if (!m_disc) begin
                    m_full  = 1'b1;
                    m_instr = imem_resp_data;
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 32'd4;
                end
                m_disc = 1'b0;
            end else begin
                if (m_full && id_ready) begin
                    m_full  = 1'b0;
                    m_instr = NOP;
                end
                if (m_fire) begin
                    m_out  = 1'b1;
                    m_disc = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            chk1("req_valid", imem_req_valid, exp_req());
            chk("imem_addr", imem_addr, m_pc);
            chk1("id_valid", id_valid, m_full);
            chk("id_instr", id_instr, m_instr);
            if (m_full) chk("id_pc", id_pc, m_ipc);
        end
    end

    // ---------------- memory emulation ----------------
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat      = 0;
    bit          ovr_en   = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    bit          hs;
    logic [31:0] hs_addr;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00a0_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_addr;
        @(posedge clk);
        #1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        if (hs) begin
            mem_busy = 1'b1;
            mem_wait = lat;
            mem_addr = hs_addr;
        end
        if (mem_busy) begin
            if (mem_wait == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = ovr_en ? ovr_data : memfn(mem_addr);
                mem_busy        = 1'b0;
            end else begin
                mem_wait--;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        id_ready        = 1'b1;

        tick();
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b0;

        // zero-wait fetch stream
        #1;
        chk1("c0_req_valid", imem_req_valid, 1'b1);
        tick(); #1;
        chk1("c1_req_valid", imem_req_valid, 1'b0);
        chk1("c1_id_valid", id_valid, 1'b0);
        tick(); #1;
        chk1("c2_id_valid", id_valid, 1'b1);
        chk("c2_id_instr", id_instr, 32'h0050_0093);
        chk("c2_id_pc", id_pc, 32'h0);
        chk("c2_addr", imem_addr, 32'h4);
        tick(); #1;
        chk1("c3_id_valid", id_valid, 1'b0);
        chk("c3_id_instr", id_instr, 32'h0000_0013);
        tick();
        chk1("c4_id_valid", id_valid, 1'b1);
        chk("c4_id_instr", id_instr, 32'h00a0_0113);
        chk("c4_id_pc", id_pc, 32'h4);
        chk("c4_addr", imem_addr, 32'h8);

        // decode stall for 5 cycles
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            #1;
            chk1("stall_id_valid", id_valid, 1'b1);
            chk("stall_id_instr", id_instr, 32'h00a0_0113);
            chk("stall_id_pc", id_pc, 32'h4);
            chk1("stall_req_valid", imem_req_valid, 1'b0);
        end
        tick();
        id_ready = 1'b1;
        #1;
        chk1("release_req_valid", imem_req_valid, 1'b1);
        chk("release_addr", imem_addr, 32'h8);
        tick();
        tick(); #1;
        chk1("f8_id_valid", id_valid, 1'b1);
        chk("f8_id_pc", id_pc, 32'h8);
        chk("f8_id_instr", id_instr, memfn(32'h8));
        chk("f8_addr", imem_addr, 32'hC);

        // memory not ready for 3 cycles
        imem_req_ready = 1'b0;
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            chk1("nrdy_req_valid", imem_req_valid, 1'b1);
            chk("nrdy_addr", imem_addr, 32'hC);
        end
        tick();
        imem_req_ready = 1'b1;
        #1;
        chk1("rdy_req_valid", imem_req_valid, 1'b1);
        chk("rdy_addr", imem_addr, 32'hC);
        tick();

        // redirect while waiting; late response must be dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        ovr_en         = 1'b1;
        ovr_data       = 32'hDEAD_BEEF;
        #1;
        chk1("rdw_req_valid", imem_req_valid, 1'b0);
        tick(); #1;
        chk("kill_addr", imem_addr, 32'h100);
        chk1("kill_req_valid", imem_req_valid, 1'b0);
        chk1("kill_id_valid", id_valid, 1'b0);
        tick(); #1;
        chk1("kill2_req_valid", imem_req_valid, 1'b0);
        tick(); #1;
        chk1("kill_resp_stim", imem_resp_valid, 1'b1);
        chk1("kill3_id_valid", id_valid, 1'b0);
        ovr_en = 1'b0;
        lat    = 0;
        tick(); #1;
        chk1("dropped_id_valid", id_valid, 1'b0);
        chk("dropped_id_instr", id_instr, 32'h0000_0013);
        chk("dropped_addr", imem_addr, 32'h100);
        chk1("dropped_req_valid", imem_req_valid, 1'b1);

        // redirect coincident with response
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        chk1("rdr_req_valid", imem_req_valid, 1'b0);
        tick(); #1;
        chk1("rdr_id_valid", id_valid, 1'b0);
        chk("rdr_id_instr", id_instr, 32'h0000_0013);
        chk("rdr_addr", imem_addr, 32'h200);

        // redirect to top of address space, then wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk1("top_req_valid", imem_req_valid, 1'b0);
        tick(); #1;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        chk1("top_req_valid2", imem_req_valid, 1'b1);
        tick();
        tick(); #1;
        chk1("wrap_id_valid", id_valid, 1'b1);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // reset with a request outstanding; late response arrives in REQ
        lat = 2;
        tick();
        rst = 1'b1;
        #1;
        chk1("mrst_req_valid", imem_req_valid, 1'b0);
        tick();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk1("mrst_id_valid", id_valid, 1'b0);
        chk("mrst_id_instr", id_instr, 32'h0000_0013);
        chk("mrst_addr", imem_addr, 32'h0);
        tick(); #1;
        chk1("late_resp_stim", imem_resp_valid, 1'b1);
        chk1("late_id_valid", id_valid, 1'b0);
        imem_req_ready = 1'b1;
        lat = 0;
        tick();
        tick(); #1;
        chk1("after_rst_id_valid", id_valid, 1'b1);
        chk("after_rst_id_pc", id_pc, 32'h0);
        chk("after_rst_id_instr", id_instr, 32'h0050_0093);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst            = ($urandom_range(0, 299) == 0);
            imem_req_ready = ($urandom_range(0, 9) < 8);
            id_ready       = ($urandom_range(0, 9) < 7);
            lat            = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                             : $urandom;
            end
            if (!mem_busy && !imem_resp_valid && $urandom_range(0, 29) == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = $urandom;
            end
        end
        rst = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID output register; sits directly upstream of decode and the immediate generator.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Captures the returned 32-bit instruction with its PC into a single-entry output slot consumed by decode.
- Supports decode back-pressure and a one-cycle redirect (branch/jump taken) that flushes stale work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on id_instr while the slot is empty or after reset (ADDI x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  32  fetch address; equals the pc register.
- imem_resp_valid  input  1  instruction data valid this cycle.
- imem_resp_data  input  32  returned instruction.
- redirect_valid  input  1  single-cycle redirect strobe.
- redirect_pc  input  32  new fetch target.
- id_valid  output  1  output slot holds a valid instruction.
- id_ready  input  1  decode consumes the slot this cycle.
- id_instr  output  32  instruction for decode / immediate generation.
- id_pc  output  32  address of id_instr.

Behaviour:
- Reset (rst=1 at the edge): pc=RESET_PC, state=REQ, id_valid=0, id_instr=NOP_INSTR, id_pc=0. imem_req_valid=0 in the reset cycle, because it is gated by !rst.
- States:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - KILL: one outstanding request whose response must be discarded.
- Request issue:
  - imem_req_valid = (state==REQ) && !rst && !redirect_valid && (!id_valid || id_ready).
  - Handshake occurs when imem_req_valid && imem_req_ready; the next state is WAIT.
  - If imem_req_ready=0, hold imem_addr and stay in REQ. imem_req_valid may drop only when its own enabling condition drops.
- Response in WAIT (imem_resp_valid=1):
  - id_instr<=imem_resp_data, id_pc<=pc, id_valid<=1, pc<=pc+4, state<=REQ.
  - imem_resp_valid is ignored in REQ.
- Slot consumption:
  - id_valid && id_ready clears id_valid next cycle unless refilled the same edge.
  - id_instr returns to NOP_INSTR when the slot empties.
- Stall: while id_valid=1 and id_ready=0, id_instr, id_pc and id_valid hold stable. No new request is issued.
- Throughput: at most one instruction per 2 cycles with a zero-wait memory. No more than one request is ever outstanding.
- Redirect (highest priority, any state):
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - id_valid<=0 and id_instr<=NOP_INSTR, overriding any same-cycle response or refill.
  - Next state by current state:
    - REQ: stays REQ.
    - WAIT with imem_resp_valid=1 this cycle: response discarded, go to REQ.
    - WAIT with no response: go to KILL.
    - KILL: stays KILL, pc updated.
- KILL: imem_resp_valid=1 discards the data, leaves pc unchanged, and goes to REQ. No requests are issued in KILL.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
- Reset mid-operation: an outstanding request is abandoned. After reset, a late imem_resp_valid in REQ is ignored.

Test Plan:
- Reset release, zero-wait memory returning {0x00500093, 0x00a00113} -> id_pc=0 then 4, id_instr matches; id_valid pulses every 2nd cycle; imem_addr sequence 0, 4, 8.
- id_ready held 0 for 5 cycles with slot full -> id_instr/id_pc stable, imem_req_valid=0. Release -> next fetch at pc+4.
- imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1, imem_addr constant, no state change.
- Redirect to 0x100 while in WAIT; the 3-cycle-late response returns 0xDEADBEEF -> response dropped, id_valid stays 0, next imem_addr=0x100.
- Redirect to 0x203 in the same cycle as a response -> id_valid=0, data dropped, next imem_addr=0x200.
- Redirect to 0xFFFF_FFFC then a normal fetch -> id_pc=0xFFFF_FFFC, next imem_addr=0x0000_0000.
